// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between NUM_REQ byte producers, locking the grant per packet.
// Optional HOLD stall timeout is built only when UART_TX_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   last,
  input  logic [8*NUM_REQ-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 send_trig,
  output logic [7:0]           send_data,
  input  logic                 tx_bsy,
  output logic                 busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || NUM_REQ > 8 || HOLD_TIMEOUT < 1) begin : g_bad_params
    $error("uart_tx_arbiter: NUM_REQ must be 1..8 and HOLD_TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {ARB, WAIT_HI, WAIT_LO, HOLD} state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_n;
  logic [PTR_W-1:0]   owner, owner_n;
  logic               lock, lock_n;
  logic [NUM_REQ-1:0] grant_n, ack_n;
  logic               send_trig_n;
  logic [7:0]         send_data_n;

  logic [PTR_W-1:0]   win_idx, scan, sel;
  logic               win_found, issue;
  logic [NUM_REQ-1:0] sel_oh;
  logic [7:0]         sel_data;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_RAW = $clog2(HOLD_TIMEOUT + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
  logic [TO_W-1:0] to_cnt, to_cnt_n;
`endif

  // Pointer increment that wraps at NUM_REQ rather than at the next power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (int'(p) >= NUM_REQ - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    scan      = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  // Inside a locked packet only the owner may send; otherwise the round-robin winner.
  assign sel    = (state == HOLD) ? owner : win_idx;
  assign issue  = ((state == ARB) && win_found) || ((state == HOLD) && req[owner]);
  assign sel_oh = NUM_REQ'(1) << sel;

  always_comb begin
    sel_data = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel == PTR_W'(i)) sel_data = data[8*i +: 8];
    end
  end

  always_comb begin
    // NOTE: every variable gets its default before the case, so no path can infer a latch.
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    owner_n     = owner;
    lock_n      = lock;
    grant_n     = grant;
    ack_n       = '0;
    send_trig_n = 1'b0;
    send_data_n = send_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
    to_cnt_n    = to_cnt;
`endif

    unique case (state)
      ARB, HOLD: begin
        if (issue) begin
          state_n     = WAIT_HI;
          owner_n     = sel;
          grant_n     = sel_oh;
          ack_n       = sel_oh;
          send_trig_n = 1'b1;
          send_data_n = sel_data;
          lock_n      = ~last[sel];
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (state == HOLD) begin
          if (to_cnt == TO_W'(HOLD_TIMEOUT - 1)) begin
            lock_n   = 1'b0;
            grant_n  = '0;
            rr_ptr_n = wrap_inc(owner);
            to_cnt_n = '0;
            state_n  = ARB;
          end else begin
            to_cnt_n = to_cnt + TO_W'(1);
          end
        end
`endif
      end
      WAIT_HI: begin
        if (tx_bsy) state_n = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_bsy) begin
          if (lock) begin
            state_n = HOLD;
`ifdef UART_TX_ARB_TIMEOUT_EN
            to_cnt_n = '0;
`endif
          end else begin
            grant_n  = '0;
            rr_ptr_n = wrap_inc(owner);
            state_n  = ARB;
          end
        end
      end
      default: state_n = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update order-independent.
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      lock      <= 1'b0;
      grant     <= '0;
      ack       <= '0;
      send_trig <= 1'b0;
      send_data <= 8'h00;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      owner     <= owner_n;
      lock      <= lock_n;
      grant     <= grant_n;
      ack       <= ack_n;
      send_trig <= send_trig_n;
      send_data <= send_data_n;
`ifdef UART_TX_ARB_TIMEOUT_EN
      to_cnt    <= to_cnt_n;
`endif
    end
  end

  assign busy = (state != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx model (start, 8 data, stop bits).
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int BIT_CYC = 3;
  localparam int FRAME   = 10 * BIT_CYC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  last = 2'b00;
  logic [15:0] data = 16'h0000;
  logic [1:0]  ack, grant;
  logic        send_trig, busy;
  logic [7:0]  send_data;
  logic        tx_bsy = 1'b0;
  logic        tx = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int bit_cnt = 0;
  int unstable_cnt = 0;
  int trig_bsy_cnt = 0;
  int g1_cnt = 0;
  logic [7:0] frame_byte = 8'h00;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q [$];

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
    .ack(ack), .grant(grant), .send_trig(send_trig), .send_data(send_data),
    .tx_bsy(tx_bsy), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic tx_bit(input logic [7:0] d, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return d[pos-1];
    return 1'b1;
  endfunction

  // uart_tx model: busy one cycle after send_trig, resamples send_data every bit.
  always @(posedge clk) begin
    if (rst) begin
      tx_bsy  <= 1'b0;
      tx      <= 1'b1;
      bit_cnt <= 0;
    end else if (!tx_bsy) begin
      if (send_trig) begin
        tx_bsy     <= 1'b1;
        tx         <= 1'b0;
        bit_cnt    <= 0;
        frame_byte <= send_data;
      end
    end else begin
      if (send_data !== frame_byte) unstable_cnt <= unstable_cnt + 1;
      if ((bit_cnt % BIT_CYC) == 1 && (bit_cnt / BIT_CYC) >= 1 && (bit_cnt / BIT_CYC) <= 8)
        rx_byte[(bit_cnt / BIT_CYC) - 1] <= tx;
      if (bit_cnt == FRAME - 1) begin
        tx_bsy <= 1'b0;
        tx     <= 1'b1;
        rx_q.push_back(rx_byte);
      end else begin
        bit_cnt <= bit_cnt + 1;
        tx      <= tx_bit(send_data, (bit_cnt + 1) / BIT_CYC);
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && send_trig && tx_bsy) trig_bsy_cnt <= trig_bsy_cnt + 1;
    if (!rst && grant[1]) g1_cnt <= g1_cnt + 1;
  end

  initial begin
    #1_000_000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_trig(input string tag, output int stamp);
    int n = 0;
    @(negedge clk);
    while (send_trig !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    stamp = cyc;
    check({tag, "_trig_seen"}, 32'(send_trig), 32'd1);
  endtask

  task automatic wait_bsy(input string tag, input logic level, output int stamp);
    int n = 0;
    while (tx_bsy !== level && n < 200) begin
      @(negedge clk);
      n++;
    end
    stamp = cyc;
    check({tag, "_bsy_level"}, 32'(tx_bsy), 32'(level));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy !== 1'b0 || tx_bsy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {30'h0, busy, tx_bsy}, 32'h0);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    got = 8'hxx;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    check(tag, {24'h0, got}, {24'h0, exp});
  endtask

  task automatic check_issue(input string tag, input logic [7:0] exp_data, input logic [1:0] exp_oh);
    check({tag, "_data"}, 32'(send_data), 32'(exp_data));
    check({tag, "_ack"}, 32'(ack), 32'(exp_oh));
    check({tag, "_grant"}, 32'(grant), 32'(exp_oh));
  endtask

  initial begin
    int t0, t1, c0, g1_base;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_trig", 32'(send_trig), 32'h0);
    check("rst_data", 32'(send_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single byte: trig/ack/grant one cycle after req, grant released after the frame
    rst = 1'b0;
    req = 2'b01; data[7:0] = 8'h41; last = 2'b01;
    t0 = cyc;
    wait_trig("single", t1);
    check("single_latency", 32'(t1 - t0), 32'd1);
    check_issue("single", 8'h41, 2'b01);
    check("single_busy", 32'(busy), 32'h1);
    req = 2'b00;
    @(negedge clk);
    check("single_ack_pulse", {30'h0, ack}, 32'h0);
    check("single_trig_pulse", 32'(send_trig), 32'h0);
    check("single_grant_held", 32'(grant), 32'h1);
    wait_idle("single");
    check("single_grant_free", 32'(grant), 32'h0);
    check("single_tx_idle", 32'(tx), 32'h1);
    check_rx("single_rx", 8'h41);

    // Tie from reset: 0 then 1, then rr_ptr wraps back to 0
    rst = 1'b1; req = 2'b11; last = 2'b11; data = 16'hB1A0;
    @(negedge clk);
    rst = 1'b0;
    t0 = cyc;
    wait_trig("tie0", t1);
    check("tie0_latency", 32'(t1 - t0), 32'd1);
    check_issue("tie0", 8'hA0, 2'b01);
    data[7:0] = 8'hA2;
    wait_trig("tie1", t1);
    check_issue("tie1", 8'hB1, 2'b10);
    data[15:8] = 8'hB3;
    wait_trig("tie2", t1);
    check_issue("tie2", 8'hA2, 2'b01);
    req = 2'b10;
    wait_trig("tie3", t1);
    check_issue("tie3", 8'hB3, 2'b10);
    req = 2'b00;
    wait_idle("tie");
    check_rx("tie_rx0", 8'hA0);
    check_rx("tie_rx1", 8'hB1);
    check_rx("tie_rx2", 8'hA2);
    check_rx("tie_rx3", 8'hB3);

    // Packet lock: three bytes from 0 while 1 waits
    rst = 1'b1; req = 2'b11; last = 2'b10; data = 16'hC101;
    @(negedge clk);
    rst = 1'b0;
    wait_trig("lock0", t1);
    check_issue("lock0", 8'h01, 2'b01);
    g1_base = g1_cnt;
    data[7:0] = 8'h02;
    wait_trig("lock1", t1);
    check_issue("lock1", 8'h02, 2'b01);
    data[7:0] = 8'h03; last = 2'b11;
    wait_trig("lock2", t1);
    check_issue("lock2", 8'h03, 2'b01);
    req = 2'b10;
    check("lock_no_grant1", 32'(g1_cnt - g1_base), 32'd0);
    wait_trig("lock3", t1);
    check_issue("lock3", 8'hC1, 2'b10);
    req = 2'b00;
    wait_idle("lock");
    check_rx("lock_rx0", 8'h01);
    check_rx("lock_rx1", 8'h02);
    check_rx("lock_rx2", 8'h03);
    check_rx("lock_rx3", 8'hC1);

    // Back-to-back: next trig two cycles after tx_bsy first seen low
    req = 2'b01; last = 2'b01; data[7:0] = 8'h10;
    wait_trig("b2b0", t1);
    check_issue("b2b0", 8'h10, 2'b01);
    data[7:0] = 8'h11;
    wait_bsy("b2b0", 1'b1, c0);
    wait_bsy("b2b0", 1'b0, c0);
    wait_trig("b2b1", t1);
    check("b2b1_gap", 32'(t1 - c0), 32'd2);
    check_issue("b2b1", 8'h11, 2'b01);
    data[7:0] = 8'h12;
    wait_bsy("b2b1", 1'b1, c0);
    wait_bsy("b2b1", 1'b0, c0);
    wait_trig("b2b2", t1);
    check("b2b2_gap", 32'(t1 - c0), 32'd2);
    check_issue("b2b2", 8'h12, 2'b01);
    req = 2'b00;
    wait_idle("b2b");
    check_rx("b2b_rx0", 8'h10);
    check_rx("b2b_rx1", 8'h11);
    check_rx("b2b_rx2", 8'h12);

    // Stalled packet: requester 0 leaves the lock open while 1 waits
    req = 2'b01; last = 2'b00; data[7:0] = 8'h55;
    wait_trig("stall0", t1);
    check_issue("stall0", 8'h55, 2'b01);
    req = 2'b10; last = 2'b10; data[15:8] = 8'h66;
    wait_bsy("stall0", 1'b1, c0);
    wait_bsy("stall0", 1'b0, c0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    repeat (20) @(negedge clk);
    check("to_grant_held", 32'(grant), 32'h1);
    check("to_busy_held", 32'(busy), 32'h1);
    @(negedge clk);
    check("to_grant_free", 32'(grant), 32'h0);
    check("to_busy_free", 32'(busy), 32'h0);
    @(negedge clk);
    check("to_next_trig", 32'(send_trig), 32'h1);
    check_issue("to_next", 8'h66, 2'b10);
    req = 2'b00;
    wait_idle("to");
    check_rx("to_rx0", 8'h55);
    check_rx("to_rx1", 8'h66);
`else
    repeat (40) @(negedge clk);
    check("hold_grant", 32'(grant), 32'h1);
    check("hold_busy", 32'(busy), 32'h1);
    check("hold_no_trig", 32'(send_trig), 32'h0);
    req = 2'b11; last = 2'b11; data[7:0] = 8'h56;
    wait_trig("hold_end", t1);
    check_issue("hold_end", 8'h56, 2'b01);
    req = 2'b10;
    wait_trig("hold_next", t1);
    check_issue("hold_next", 8'h66, 2'b10);
    req = 2'b00;
    wait_idle("hold");
    check_rx("hold_rx0", 8'h55);
    check_rx("hold_rx1", 8'h56);
    check_rx("hold_rx2", 8'h66);
`endif

    // Reset mid-frame: rr_ptr is 1 beforehand, arbitration restarts at 0
    req = 2'b01; last = 2'b01; data[7:0] = 8'h77;
    wait_trig("mid0", t1);
    check_issue("mid0", 8'h77, 2'b01);
    req = 2'b00;
    wait_idle("mid0");
    req = 2'b10; last = 2'b10; data[15:8] = 8'h88;
    wait_trig("mid1", t1);
    check_issue("mid1", 8'h88, 2'b10);
    req = 2'b00;
    wait_bsy("mid1", 1'b1, c0);
    repeat (5) @(negedge clk);
    rst = 1'b1; req = 2'b11; last = 2'b11; data = 16'h889A;
    @(negedge clk);
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_trig", 32'(send_trig), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_tx", 32'(tx), 32'h1);
    rst = 1'b0;
    wait_trig("mid2", t1);
    check_issue("mid2", 8'h9A, 2'b01);
    req = 2'b00;
    wait_idle("mid2");
    check_rx("mid_rx0", 8'h77);
    check_rx("mid_rx1", 8'h9A);

    check("rx_queue_empty", 32'(rx_q.size()), 32'd0);
    check("trig_while_bsy", 32'(trig_bsy_cnt), 32'd0);
    check("data_unstable", 32'(unstable_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
